// File: rtl/hp_post_normalizer.sv
// Purpose: renormalize a raw half-precision mantissa sum into packed sign/exp/frac with zero/ovf flags.
// Latency: result valid 1+k edges after capture (k = left shifts, k <= MW-1); carry/zero/normal take 1.
// Backpressure: single-entry; in_ready only in IDLE, result held in DONE until out_ready.
module hp_post_normalizer #(
  parameter int EW = 5,
  parameter int MW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [EW-1:0] in_exp,
  input  logic [MW:0]   in_mant,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sign,
  output logic [EW-1:0] out_exp,
  output logic [MW-2:0] out_frac,
  output logic          out_zero,
  output logic          out_ovf
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [EW-1:0] EXP_ONE = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] EXP_MAX = {EW{1'b1}};

  logic [1:0]    state;
  logic          sign;
  logic [EW-1:0] exp;
  logic [MW:0]   mant;
  logic [EW:0]   exp_inc;
  logic          inc_ovf;

  // Handshake flags decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Carry path: increment is one bit wider so an all-ones input exponent
  // still reports overflow instead of wrapping to zero.
  assign exp_inc = {1'b0, exp} + {{EW{1'b0}}, 1'b1};
  assign inc_ovf = (exp_inc >= {1'b0, EXP_MAX});

  // Capture, iterative normalization and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sign     <= 1'b0;
      exp      <= '0;
      mant     <= '0;
      out_sign <= 1'b0;
      out_exp  <= '0;
      out_frac <= '0;
      out_zero <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign  <= in_sign;
            mant  <= in_mant;
            // Subnormal operands carry an effective exponent of 1.
            exp   <= (in_exp == '0) ? EXP_ONE : in_exp;
            state <= NORM;
          end
        end
        NORM: begin
          if (mant == '0) begin
            out_sign <= sign;
            out_exp  <= '0;
            out_frac <= '0;
            out_zero <= 1'b1;
            out_ovf  <= 1'b0;
            state    <= DONE;
          end else if (mant[MW]) begin
            // Carry out of the adder: one right shift, LSB truncated.
            out_sign <= sign;
            out_zero <= 1'b0;
            if (inc_ovf) begin
              out_exp  <= EXP_MAX;
              out_frac <= '0;
              out_ovf  <= 1'b1;
            end else begin
              out_exp  <= exp_inc[EW-1:0];
              out_frac <= mant[MW-1:1];
              out_ovf  <= 1'b0;
            end
            state <= DONE;
          end else if (mant[MW-1]) begin
            out_sign <= sign;
            out_exp  <= exp;
            out_frac <= mant[MW-2:0];
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
            state    <= DONE;
          end else if (exp == EXP_ONE) begin
            // Cannot shift further without going below exp 1: subnormal result.
            out_sign <= sign;
            out_exp  <= '0;
            out_frac <= mant[MW-2:0];
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
            state    <= DONE;
          end else begin
            mant <= {mant[MW-1:0], 1'b0};
            exp  <= exp - EXP_ONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
